// File: rtl/sound_pkg.sv
// Shared sequencer types and note pitch constants.
// Pitch values are maxval settings for the downstream sine clkgen.
package sound_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PLAY, ST_DONE} state_t;

    localparam int REST  = 0;
    localparam int D     = 27;
    localparam int E     = 24;
    localparam int FIS   = 21;
    localparam int G     = 20;
    localparam int A     = 18;
    localparam int B     = 16;
    localparam int C     = 15;
    localparam int DHIGH = 13;
endpackage

// File: rtl/note_sequencer_if.sv
// Control, score-load and audio-output bundle of the note sequencer.
interface note_sequencer_if #(
    parameter int PITCH_W = 5,
    parameter int DUR_W   = 4,
    parameter int TEMPO_W = 13,
    parameter int ADDR_W  = 5,
    parameter int LEN_W   = 6
) ();
    logic               tick;
    logic               start;
    logic               stop;
    logic               loop_en;
    logic               artic_en;
    logic [LEN_W-1:0]   len;
    logic [TEMPO_W-1:0] tempo_div;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PITCH_W-1:0] wr_pitch;
    logic [DUR_W-1:0]   wr_dur;
    logic [PITCH_W-1:0] pitch_o;
    logic               gate;
    logic               note_start;
    logic [ADDR_W-1:0]  idx_o;
    logic               busy;
    logic               done;

    modport master (
        output tick, start, stop, loop_en, artic_en, len, tempo_div,
               wr_en, wr_addr, wr_pitch, wr_dur,
        input  pitch_o, gate, note_start, idx_o, busy, done
    );
    modport slave (
        input  tick, start, stop, loop_en, artic_en, len, tempo_div,
               wr_en, wr_addr, wr_pitch, wr_dur,
        output pitch_o, gate, note_start, idx_o, busy, done
    );
endinterface

// File: rtl/score_ram.sv
// Score storage: one write port, one registered read port, read-before-write
// on an address collision.
module score_ram #(
    parameter int NOTES  = 32,
    parameter int W      = 9,
    parameter int ADDR_W = $clog2(NOTES)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [W-1:0]      i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [W-1:0]      o_rd_data
);
    logic [W-1:0] r_mem [NOTES];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/note_sequencer.sv
// Run-time loadable melody sequencer: plays (pitch, duration) entries from
// score_ram, paced by the sample tick and a tempo divider.
module note_sequencer
    import sound_pkg::*;
#(
    parameter int NOTES   = 32,
    parameter int PITCH_W = 5,
    parameter int DUR_W   = 4,
    parameter int TEMPO_W = 13,
    parameter int ADDR_W  = $clog2(NOTES),
    parameter int LEN_W   = $clog2(NOTES) + 1
) (
    input  logic           clk,
    input  logic           reset,
    note_sequencer_if.slave io_seq
);
    state_t               r_state;
    logic [ADDR_W-1:0]    r_idx;
    logic [LEN_W-1:0]     r_len;
    logic [TEMPO_W-1:0]   r_tempo, r_unit_ctr;
    logic [DUR_W-1:0]     r_dur, r_dur_ctr;
    logic [PITCH_W-1:0]   r_pitch;
    logic                 r_gate, r_note_start, r_busy, r_done;

    logic [ADDR_W-1:0]        w_rd_addr;
    logic [PITCH_W+DUR_W-1:0] w_rd_data;
    logic [PITCH_W-1:0]       w_rd_pitch;
    logic [DUR_W-1:0]         w_rd_dur;
    logic                     w_unit_wrap, w_note_end, w_more;

    assign w_rd_pitch  = w_rd_data[PITCH_W+DUR_W-1:DUR_W];
    assign w_rd_dur    = w_rd_data[DUR_W-1:0];
    assign w_unit_wrap = io_seq.tick && (r_unit_ctr == r_tempo - TEMPO_W'(1));
    assign w_note_end  = (r_state == ST_PLAY) && w_unit_wrap &&
                         (r_dur_ctr == r_dur - DUR_W'(1));
    assign w_more      = {1'b0, r_idx} < (r_len - LEN_W'(1));

    // Address is the index entering FETCH, so the RAM output is valid during FETCH.
    always_comb begin
        w_rd_addr = r_idx;
        if (r_state == ST_IDLE) w_rd_addr = '0;
        else if (w_note_end)    w_rd_addr = w_more ? r_idx + ADDR_W'(1) : '0;
    end

    score_ram #(.NOTES(NOTES), .W(PITCH_W + DUR_W), .ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .i_wr_en   (io_seq.wr_en),
        .i_wr_addr (io_seq.wr_addr),
        .i_wr_data ({io_seq.wr_pitch, io_seq.wr_dur}),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_tempo      <= '0;
            r_unit_ctr   <= '0;
            r_dur        <= '0;
            r_dur_ctr    <= '0;
            r_pitch      <= '0;
            r_gate       <= 1'b0;
            r_note_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
            if (r_state != ST_IDLE && io_seq.stop) begin
                r_state <= ST_IDLE;
                r_gate  <= 1'b0;
                r_busy  <= 1'b0;
                r_pitch <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (io_seq.start && !io_seq.stop && io_seq.len != '0) begin
                            r_len   <= io_seq.len;
                            r_tempo <= (io_seq.tempo_div == '0) ? TEMPO_W'(1) : io_seq.tempo_div;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_pitch      <= w_rd_pitch;
                        r_dur        <= (w_rd_dur == '0) ? DUR_W'(1) : w_rd_dur;
                        r_unit_ctr   <= '0;
                        r_dur_ctr    <= '0;
                        r_gate       <= (w_rd_pitch != '0);
                        r_note_start <= 1'b1;
                        r_state      <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (w_note_end) begin
                            r_gate <= 1'b0;
                            if (w_more || io_seq.loop_en) begin
                                r_idx   <= w_rd_addr;
                                r_state <= ST_FETCH;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        end else if (w_unit_wrap) begin
                            r_unit_ctr <= '0;
                            r_dur_ctr  <= r_dur_ctr + DUR_W'(1);
                            // Articulation mutes the final unit of multi-unit notes.
                            r_gate     <= (r_pitch != '0) &&
                                          !(io_seq.artic_en && r_dur > DUR_W'(1) &&
                                            (r_dur_ctr + DUR_W'(1) == r_dur - DUR_W'(1)));
                        end else if (io_seq.tick) begin
                            r_unit_ctr <= r_unit_ctr + TEMPO_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_pitch <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign io_seq.pitch_o    = r_pitch;
    assign io_seq.gate       = r_gate;
    assign io_seq.note_start = r_note_start;
    assign io_seq.idx_o      = r_idx;
    assign io_seq.busy       = r_busy;
    assign io_seq.done       = r_done;
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Parametrised, run-time-loadable melody sequencer. Replaces the hard-coded 20-note player.
- Plays a score of (pitch maxval, duration) entries held in an internal writable RAM. Durations are paced by a sample-rate tick and a run-time tempo divider.
- Drives the sine clkgen maxval and a gate. Emits a note_start strobe so the downstream clkgen/sine can restart phase on every pitch change.
- Adds start/stop control, loop mode, rests, articulation gap and a done indication.

Parameters:
- NOTES, 32, score depth in entries (power of two)
- PITCH_W, 5, width of the pitch maxval field; value 0 encodes a rest
- DUR_W, 4, width of the duration field, in units
- TEMPO_W, 13, width of the tempo divider (ticks per unit)
- ADDR_W, $clog2(NOTES), score address width
- LEN_W, $clog2(NOTES)+1, score length width

Ports:
- clk  in  1  system clock (1 MHz)
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide sample-rate enable (fs strobe)
- start  in  1  begin playback from entry 0
- stop  in  1  abort playback
- loop_en  in  1  restart at entry 0 after the last note
- artic_en  in  1  silence the gate during the final unit of notes longer than 1 unit
- len  in  LEN_W  number of valid entries (1..NOTES)
- tempo_div  in  TEMPO_W  ticks per duration unit; 0 is treated as 1
- wr_en  in  1  score write strobe
- wr_addr  in  ADDR_W  score write address
- wr_pitch  in  PITCH_W  pitch data to write
- wr_dur  in  DUR_W  duration data to write
- pitch_o  out  PITCH_W  maxval for the sine clkgen
- gate  out  1  1 = tone audible
- note_start  out  1  one-cycle pulse on the first PLAY cycle of every note
- idx_o  out  ADDR_W  index of the current entry
- busy  out  1  high in FETCH or PLAY
- done  out  1  one-cycle pulse when a non-looping score ends

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0. The score RAM is not cleared.
- States: IDLE, FETCH, PLAY, DONE.
- IDLE:
  - start=1 with len!=0: latch len and tempo_div (0 -> 1), set idx=0, go to FETCH.
  - start with len==0 is ignored.
- FETCH (1 cycle): synchronous read of entry idx. On the exiting edge, load pitch_o and the note duration (dur 0 -> 1), clear unit_ctr and dur_ctr, go to PLAY.
- Start latency: start sampled at edge k -> FETCH during cycle k+1 -> PLAY with pitch_o valid and note_start=1 during cycle k+2.
- PLAY duration counting:
  - Only cycles with tick=1 count.
  - unit_ctr counts 0..tempo-1; on wrap, dur_ctr increments.
  - The note ends on the tick where unit_ctr==tempo-1 and dur_ctr==dur-1.
  - Note length is exactly dur*tempo ticks.
- Gate:
  - gate=1 in PLAY, except when pitch==0 (rest).
  - With artic_en=1, dur>1 and dur_ctr==dur-1, gate=0.
  - gate=0 in FETCH, IDLE and DONE.
  - pitch_o holds its value through FETCH until reloaded.
- Note end:
  - If idx<len-1: idx+1, go to FETCH.
  - Else if loop_en (sampled at the end edge): idx=0, go to FETCH.
  - Else: go to DONE.
- DONE (1 cycle): done=1, then IDLE. pitch_o is cleared to 0 on entry to IDLE.
- stop: has priority over everything in any non-IDLE state. Next state is IDLE, gate=0, no done pulse. start and stop in the same cycle -> stop wins.
- start while busy is ignored. len and tempo_div changes during playback are ignored until the next start.
- Writes are accepted in every state.
  - A write to the address being read in the same FETCH cycle returns the old data (read-before-write).
  - The new data applies on the next fetch.
- reset mid-playback: same result as power-on reset on the next edge.
- Counter widths never overflow: dur_ctr is DUR_W, unit_ctr is TEMPO_W, all compares are unsigned.

Decomposition:
- Shared package sound_pkg holds:
  - state enum
  - REST=0
  - note maxval constants D=27, E=24, FIS=21, G=20, A=18, B=16, C=15, DHIGH=13
- One sub-module, score_ram: NOTES x (PITCH_W+DUR_W), one synchronous write port, one synchronous read port, read-before-write.

Test Plan:
- Load 3 entries {G,2},{0,1},{A,1}; len=3, tempo_div=4; start -> note_start at start+2 cycles; pitch_o 20 for 8 ticks, gate 0 for 4 ticks, 18 for 4 ticks; done pulses once; return to IDLE.
- Same score with loop_en=1 -> after entry 2, idx_o=0, note_start again, no done pulse; stop -> gate=0 and busy=0 on the next cycle.
- artic_en=1, entry {B,4}, tempo_div=1 -> gate high for ticks 1-3, low on tick 4.
- Edge values: tempo_div=0 and dur=0 -> note lasts 1 tick; len=0 with start -> stays IDLE, busy=0.
- start and stop in the same cycle in IDLE -> stays IDLE. reset during PLAY -> all outputs 0 on the next edge; RAM contents are preserved on replay.
- During FETCH of idx 1, write the same address -> the old pitch plays; the new pitch plays on the next loop iteration.
